i2c_apb_sequencer: RTL and testbench
====================================

Name: i2c_apb_sequencer

Overview:
- APB master that sequences one complete I2C transaction through the I2C register block.
- Register block map: 0x00 prescaler, 0x01 cmd, 0x02 transmit, 0x03 receive, 0x04 address_rw, 0x05 status.
- Accepts a single-byte read or write request from a host, then:
  - programs prescaler, address_rw and (for writes) transmit;
  - issues the start command;
  - polls status until done or timeout;
  - for reads, fetches the received byte;
  - clears cmd and returns a one-cycle response.

Parameters:
CMD_START, 8'h01, value written to cmd (0x01) to launch the transfer
CMD_CLEAR, 8'h00, value written to cmd after the transfer ends
DONE_BIT, 0, status bit index meaning transfer complete
NACK_BIT, 1, status bit index meaning address/data NACK
MAX_POLLS, 255, number of status reads without done before timeout (1..255)

Ports:
PCLK_i  in  1  clock
PRESET_N_i  in  1  reset. One clock; reset is asynchronous and active-low.
req_valid_i  in  1  host request valid
req_ready_o  out  1  high only in IDLE; request accepted on req_valid_i & req_ready_o
req_rw_i  in  1  1 = I2C read, 0 = I2C write
req_addr_i  in  7  I2C slave address
req_wdata_i  in  8  byte to transmit (write requests)
req_prescaler_i  in  8  SCL prescaler value
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  8  received byte (reads, no error), else 0
rsp_err_o  out  2  00 ok, 01 nack, 10 timeout
busy_o  out  1  high from acceptance until rsp_valid_o cycle inclusive
PSEL_o  out  1  APB select
PENABLE_o  out  1  APB enable
PWRITE_o  out  1  APB direction
PADDR_o  out  8  APB address
PWDATA_o  out  8  APB write data
PRDATA_i  in  8  APB read data
PREADY_i  in  1  APB ready

Behaviour:
- Reset (async, any state): all outputs 0, except req_ready_o = 1; all FSMs to IDLE; captured request and poll counter cleared. PSEL_o drops immediately; any partial APB transfer is abandoned. No response is issued for an aborted transaction.
- Request capture: on accept, req_rw/addr/wdata/prescaler are latched. The inputs are ignored until the next IDLE.
- APB sub-FSM (APB_IDLE, SETUP, ACCESS):
  - SETUP: one cycle, PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA valid.
  - ACCESS: PSEL=1, PENABLE=1, held until PREADY_i=1.
  - On the PREADY_i=1 cycle: PRDATA_i is captured for reads, and the next step's SETUP begins the following cycle.
  - PREADY_i is sampled only in ACCESS; a stale PREADY_i in SETUP is ignored.
  - Address, data and direction are stable from SETUP through completion.
  - No PREADY timeout.
  - Against the register block (registered PREADY) a transfer takes exactly 3 cycles.
- Sequence FSM, one APB transfer per state:
  - P_PRESC: write 0x00 = prescaler.
  - P_ADDR: write 0x04 = {addr, rw}.
  - P_TX: write 0x02 = wdata. Write requests only; skipped for reads.
  - P_START: write 0x01 = CMD_START. Poll counter cleared.
  - P_POLL: read 0x05, then:
    - done bit = 1: go to P_RX (read) or P_CLR (write); err = 01 if nack bit set, else 00.
    - done bit = 0 and nack bit = 1: err = 01, go to P_CLR.
    - done bit = 0 and nack bit = 0: counter++; if counter == MAX_POLLS, err = 10 and go to P_CLR; else repeat P_POLL.
  - P_RX: read 0x03, capture the byte (only entered on done with err = 00).
  - P_CLR: write 0x01 = CMD_CLEAR. Always executed, including on error.
  - RESP: rsp_valid_o = 1 for one cycle with rdata/err, then IDLE. req_ready_o returns high the cycle after RESP.
- Simultaneous done and nack in one poll → err = 01; rsp_rdata_o = 0.
- rsp_rdata_o / rsp_err_o are valid only while rsp_valid_o = 1 and are 0 otherwise.
- Latency against the register block, write with N polls: 3 × (5 + N) + 1 cycles from accept to rsp_valid_o. Read: 3 × (5 + N) + 1 (P_TX is replaced by P_RX).
- Poll counter is 8 bits and saturates; it does not wrap.

Test Plan:
- Write: req rw=0, addr=0x50, wdata=0xA5, prescaler=0x10; status 0x01 on 2nd poll → APB writes 00←10, 04←A0, 02←A5, 01←01; two reads of 05; write 01←00; rsp_err=00, rsp_rdata=00, rsp at cycle 22 after accept.
- Read: rw=1, addr=0x3C; receive=0x5A; status done on 1st poll → no write to 0x02; 04←79; read 0x03; rsp_rdata=0x5A, err=00.
- NACK: status 0x03 on 1st poll → no 0x03 read, 01←00 issued, rsp_err=01, rsp_rdata=00.
- Timeout: MAX_POLLS=4, status stays 0x00 → exactly 4 reads of 0x05, then 01←00, rsp_err=10.
- Backpressure and busy: req_valid held high during a transaction → second request accepted only after rsp_valid_o. A slave holding PREADY_i low for 5 ACCESS cycles → PADDR/PWDATA remain stable throughout.
- Async reset asserted during P_POLL → PSEL_o/PENABLE_o low without a clock edge, no rsp_valid_o, req_ready_o=1. A new request after release runs the full sequence from P_PRESC.

Source files
------------

// File: rtl/i2c_apb_sequencer.sv
// i2c_apb_sequencer: APB master that drives one complete single-byte I2C
// transaction through the I2C register block (prescaler, address, data,
// start, status polling, optional receive fetch, command clear) and returns
// a one-cycle response to the host.
module i2c_apb_sequencer #(
   parameter logic [7:0] CMD_START = 8'h01,
   parameter logic [7:0] CMD_CLEAR = 8'h00,
   parameter int         DONE_BIT  = 0,
   parameter int         NACK_BIT  = 1,
   parameter int         MAX_POLLS = 255
) (
   input  logic       PCLK_i,
   input  logic       PRESET_N_i,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic       req_rw_i,
   input  logic [6:0] req_addr_i,
   input  logic [7:0] req_wdata_i,
   input  logic [7:0] req_prescaler_i,
   output logic       rsp_valid_o,
   output logic [7:0] rsp_rdata_o,
   output logic [1:0] rsp_err_o,
   output logic       busy_o,
   output logic       PSEL_o,
   output logic       PENABLE_o,
   output logic       PWRITE_o,
   output logic [7:0] PADDR_o,
   output logic [7:0] PWDATA_o,
   input  logic [7:0] PRDATA_i,
   input  logic       PREADY_i
);

   localparam logic [7:0] LP_MAX_POLLS = 8'(MAX_POLLS);
   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_NACK     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE, S_PRESC, S_ADDR, S_TX, S_START, S_POLL, S_RX, S_CLR, S_RESP
   } seq_t;

   typedef enum logic [1:0] {
      APB_IDLE, APB_SETUP, APB_ACCESS
   } apb_t;

   seq_t       r_seq, w_seq_nxt;
   apb_t       r_apb, w_apb_nxt;
   logic       r_rw;
   logic [6:0] r_addr;
   logic [7:0] r_wdata;
   logic [7:0] r_presc;
   logic [7:0] r_poll_cnt;
   logic [7:0] r_rdata;
   logic [1:0] r_err, w_err_nxt;

   logic       w_accept;
   logic       w_xfer_done;
   logic       w_st_done;
   logic       w_st_nack;
   logic [7:0] w_cnt_inc;

   // Poll counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign w_accept    = req_valid_i & (r_seq == S_IDLE);
   assign w_xfer_done = (r_apb == APB_ACCESS) & PREADY_i;
   assign w_st_done   = PRDATA_i[DONE_BIT];
   assign w_st_nack   = PRDATA_i[NACK_BIT];
   assign w_cnt_inc   = sat_inc(r_poll_cnt);

   // State registers plus captured request, poll counter and response data.
   always_ff @(posedge PCLK_i or negedge PRESET_N_i) begin
      if (!PRESET_N_i) begin
         r_seq      <= S_IDLE;
         r_apb      <= APB_IDLE;
         r_rw       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_presc    <= '0;
         r_poll_cnt <= '0;
         r_rdata    <= '0;
         r_err      <= ERR_OK;
      end else begin
         r_seq <= w_seq_nxt;
         r_apb <= w_apb_nxt;
         if (w_accept) begin
            r_rw       <= req_rw_i;
            r_addr     <= req_addr_i;
            r_wdata    <= req_wdata_i;
            r_presc    <= req_prescaler_i;
            r_poll_cnt <= '0;
            r_rdata    <= '0;
            r_err      <= ERR_OK;
         end else begin
            r_err <= w_err_nxt;
            if (w_xfer_done && r_seq == S_START)
               r_poll_cnt <= '0;
            if (w_xfer_done && r_seq == S_POLL && !w_st_done && !w_st_nack)
               r_poll_cnt <= w_cnt_inc;
            if (w_xfer_done && r_seq == S_RX)
               r_rdata <= PRDATA_i;
         end
      end
   end

   // Sequence and APB phase next-state; each sequence step is one APB transfer.
   always_comb begin
      w_seq_nxt = r_seq;
      w_apb_nxt = r_apb;
      w_err_nxt = r_err;
      case (r_seq)
         S_IDLE:  if (w_accept) w_seq_nxt = S_PRESC;
         S_PRESC: if (w_xfer_done) w_seq_nxt = S_ADDR;
         S_ADDR:  if (w_xfer_done) w_seq_nxt = r_rw ? S_START : S_TX;
         S_TX:    if (w_xfer_done) w_seq_nxt = S_START;
         S_START: if (w_xfer_done) w_seq_nxt = S_POLL;
         S_POLL: begin
            if (w_xfer_done) begin
               if (w_st_done) begin
                  w_err_nxt = w_st_nack ? ERR_NACK : ERR_OK;
                  w_seq_nxt = (r_rw && !w_st_nack) ? S_RX : S_CLR;
               end else if (w_st_nack) begin
                  w_err_nxt = ERR_NACK;
                  w_seq_nxt = S_CLR;
               end else if (w_cnt_inc == LP_MAX_POLLS) begin
                  w_err_nxt = ERR_TIMEOUT;
                  w_seq_nxt = S_CLR;
               end
            end
         end
         S_RX:    if (w_xfer_done) w_seq_nxt = S_CLR;
         S_CLR:   if (w_xfer_done) w_seq_nxt = S_RESP;
         S_RESP:  w_seq_nxt = S_IDLE;
         default: w_seq_nxt = S_IDLE;
      endcase

      case (r_apb)
         APB_IDLE:   if (w_accept) w_apb_nxt = APB_SETUP;
         APB_SETUP:  w_apb_nxt = APB_ACCESS;
         APB_ACCESS: if (PREADY_i) w_apb_nxt = (w_seq_nxt == S_RESP) ? APB_IDLE : APB_SETUP;
         default:    w_apb_nxt = APB_IDLE;
      endcase
   end

   // APB address/data/direction decoded from the current sequence step.
   always_comb begin
      PWRITE_o = 1'b0;
      PADDR_o  = 8'h00;
      PWDATA_o = 8'h00;
      case (r_seq)
         S_PRESC: begin PWRITE_o = 1'b1; PADDR_o = 8'h00; PWDATA_o = r_presc;          end
         S_ADDR:  begin PWRITE_o = 1'b1; PADDR_o = 8'h04; PWDATA_o = {r_addr, r_rw};   end
         S_TX:    begin PWRITE_o = 1'b1; PADDR_o = 8'h02; PWDATA_o = r_wdata;          end
         S_START: begin PWRITE_o = 1'b1; PADDR_o = 8'h01; PWDATA_o = CMD_START;        end
         S_POLL:  begin PWRITE_o = 1'b0; PADDR_o = 8'h05;                              end
         S_RX:    begin PWRITE_o = 1'b0; PADDR_o = 8'h03;                              end
         S_CLR:   begin PWRITE_o = 1'b1; PADDR_o = 8'h01; PWDATA_o = CMD_CLEAR;        end
         default: begin PWRITE_o = 1'b0; PADDR_o = 8'h00; PWDATA_o = 8'h00;            end
      endcase
   end

   assign PSEL_o      = (r_apb != APB_IDLE);
   assign PENABLE_o   = (r_apb == APB_ACCESS);
   assign req_ready_o = (r_seq == S_IDLE);
   assign busy_o      = (r_seq != S_IDLE);
   assign rsp_valid_o = (r_seq == S_RESP);
   assign rsp_rdata_o = (r_seq == S_RESP) ? r_rdata : 8'h00;
   assign rsp_err_o   = (r_seq == S_RESP) ? r_err : 2'b00;

endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// Testbench for i2c_apb_sequencer: register-block slave model with
// registered PREADY and optional wait states, scoreboard of expected APB
// transfers and host responses built from a reference model of the sequence.
module tb_i2c_apb_sequencer;

   localparam int MAXP = 4;

   logic       PCLK_i = 1'b0;
   logic       PRESET_N_i = 1'b0;
   logic       req_valid_i = 1'b0;
   logic       req_ready_o;
   logic       req_rw_i = 1'b0;
   logic [6:0] req_addr_i = '0;
   logic [7:0] req_wdata_i = '0;
   logic [7:0] req_prescaler_i = '0;
   logic       rsp_valid_o;
   logic [7:0] rsp_rdata_o;
   logic [1:0] rsp_err_o;
   logic       busy_o;
   logic       PSEL_o;
   logic       PENABLE_o;
   logic       PWRITE_o;
   logic [7:0] PADDR_o;
   logic [7:0] PWDATA_o;
   logic [7:0] PRDATA_i;
   logic       PREADY_i;

   i2c_apb_sequencer #(.MAX_POLLS(MAXP)) u_dut (
      .PCLK_i(PCLK_i), .PRESET_N_i(PRESET_N_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_rw_i(req_rw_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i), .req_prescaler_i(req_prescaler_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .busy_o(busy_o),
      .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o), .PWRITE_o(PWRITE_o),
      .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o),
      .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i)
   );

   always #5 PCLK_i = ~PCLK_i;

   bit [16:0] exp_apb[$];
   bit [7:0]  exp_rd[$];
   bit [1:0]  exp_err[$];
   int        exp_lat[$];
   bit [7:0]  status_q[$];

   int        n_chk = 0;
   int        n_fail = 0;
   int        n_acc = 0;
   int        n_rsp = 0;
   int        cyc = 0;
   int        acc_cyc = 0;
   int        stall = 0;
   int        wait_cnt = 0;
   bit [7:0]  rx_val = 8'h00;
   bit [16:0] setup_snap = '0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
      end
   endtask

   // Register-block slave: PREADY registered, optional extra wait states.
   always @(posedge PCLK_i or negedge PRESET_N_i) begin
      if (!PRESET_N_i) begin
         PREADY_i <= 1'b0;
         PRDATA_i <= 8'h00;
         wait_cnt <= 0;
      end else if (PSEL_o && PENABLE_o && !PREADY_i) begin
         if (wait_cnt < stall) wait_cnt <= wait_cnt + 1;
         else begin
            PREADY_i <= 1'b1;
            if (PADDR_o == 8'h05) PRDATA_i <= (status_q.size() > 0) ? status_q[0] : 8'h00;
            else if (PADDR_o == 8'h03) PRDATA_i <= rx_val;
            else PRDATA_i <= 8'h00;
         end
      end else if (PREADY_i) begin
         PREADY_i <= 1'b0;
         wait_cnt <= 0;
         if (!PWRITE_o && PADDR_o == 8'h05 && status_q.size() > 0) void'(status_q.pop_front());
      end
   end

   always @(posedge PCLK_i) cyc <= cyc + 1;

   // Monitor on the falling edge: APB scoreboard, response scoreboard, handshake.
   always @(negedge PCLK_i) begin
      if (PRESET_N_i) begin
         chk("ready_vs_busy", 32'(req_ready_o), 32'(!busy_o));
         if (PSEL_o && !PENABLE_o) setup_snap = {PWRITE_o, PADDR_o, PWDATA_o};
         if (PSEL_o && PENABLE_o) begin
            chk("apb_stable", 32'({PWRITE_o, PADDR_o, PWDATA_o}), 32'(setup_snap));
            if (PREADY_i) begin
               chk("apb_pending", 32'(exp_apb.size() > 0), 32'd1);
               if (exp_apb.size() > 0)
                  chk("apb_xfer", 32'({PWRITE_o, PADDR_o, PWRITE_o ? PWDATA_o : 8'h00}),
                      32'(exp_apb.pop_front()));
            end
         end
         if (rsp_valid_o) begin
            chk("rsp_pending", 32'(exp_rd.size() > 0), 32'd1);
            if (exp_rd.size() > 0) begin
               chk("rsp_rdata", 32'(rsp_rdata_o), 32'(exp_rd.pop_front()));
               chk("rsp_err", 32'(rsp_err_o), 32'(exp_err.pop_front()));
               chk("rsp_latency", 32'(cyc - acc_cyc + 1), 32'(exp_lat.pop_front()));
            end
            n_rsp++;
         end else begin
            chk("rsp_quiet", 32'({rsp_rdata_o, rsp_err_o}), 32'd0);
         end
         if (req_valid_i && req_ready_o) begin
            chk("accept_after_rsp", 32'(n_acc), 32'(n_rsp));
            n_acc++;
            acc_cyc = cyc + 1;
         end
      end
   end

   // Reference model: expected APB transfers and response for one request.
   // st holds poll status bytes, first poll in st[7:0]; polls past nst see 0x00.
   task automatic push_txn(input bit rw, input bit [6:0] a, input bit [7:0] wd,
                           input bit [7:0] ps, input bit [7:0] rxb,
                           input bit [31:0] st, input int nst);
      int       sz0;
      int       polls;
      bit       fin;
      bit [7:0] s;
      bit [1:0] err;
      bit [7:0] rd;
      sz0 = exp_apb.size();
      polls = 0; fin = 0; err = 2'b00; rd = 8'h00;
      exp_apb.push_back({1'b1, 8'h00, ps});
      exp_apb.push_back({1'b1, 8'h04, {a, rw}});
      if (!rw) exp_apb.push_back({1'b1, 8'h02, wd});
      exp_apb.push_back({1'b1, 8'h01, 8'h01});
      for (int i = 0; i < nst; i++) status_q.push_back(st[i*8 +: 8]);
      while (!fin) begin
         s = (polls < nst) ? st[polls*8 +: 8] : 8'h00;
         exp_apb.push_back({1'b0, 8'h05, 8'h00});
         polls++;
         if (s[0]) begin
            err = s[1] ? 2'b01 : 2'b00;
            if (rw && !s[1]) begin
               exp_apb.push_back({1'b0, 8'h03, 8'h00});
               rd = rxb;
            end
            fin = 1;
         end else if (s[1]) begin
            err = 2'b01; fin = 1;
         end else if (polls == MAXP) begin
            err = 2'b10; fin = 1;
         end
      end
      exp_apb.push_back({1'b1, 8'h01, 8'h00});
      exp_rd.push_back(rd);
      exp_err.push_back(err);
      exp_lat.push_back((3 + stall) * (exp_apb.size() - sz0) + 1);
   endtask

   task automatic send(input bit rw, input bit [6:0] a, input bit [7:0] wd,
                       input bit [7:0] ps, input bit hold);
      bit ok;
      req_rw_i = rw; req_addr_i = a; req_wdata_i = wd; req_prescaler_i = ps;
      req_valid_i = 1'b1;
      ok = 0;
      for (int k = 0; k < 400 && !ok; k++) begin
         @(negedge PCLK_i);
         if (req_ready_o) ok = 1;
      end
      chk("accept_seen", 32'(ok), 32'd1);
      @(posedge PCLK_i); #1;
      if (!hold) req_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (exp_rd.size() > 0 && k < budget) begin
         @(posedge PCLK_i);
         k++;
      end
      chk("rsp_in_time", 32'(exp_rd.size()), 32'd0);
      chk("apb_all_seen", 32'(exp_apb.size()), 32'd0);
      @(posedge PCLK_i); #1;
   endtask

   initial begin
      bit ok;
      repeat (3) @(posedge PCLK_i);
      #1;
      chk("rst_ready", 32'(req_ready_o), 32'd1);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_psel", 32'({PSEL_o, PENABLE_o}), 32'd0);
      chk("rst_rsp", 32'({rsp_valid_o, rsp_rdata_o, rsp_err_o}), 32'd0);
      chk("rst_apb_bus", 32'({PWRITE_o, PADDR_o, PWDATA_o}), 32'd0);
      @(negedge PCLK_i) PRESET_N_i = 1'b1;
      repeat (2) @(posedge PCLK_i);
      #1;

      // Write, done on second poll: 22 cycles to response.
      push_txn(1'b0, 7'h50, 8'hA5, 8'h10, 8'h00, 32'h0000_0100, 2);
      send(1'b0, 7'h50, 8'hA5, 8'h10, 1'b0);
      wait_done(400);

      // Read, done on first poll.
      rx_val = 8'h5A;
      push_txn(1'b1, 7'h3C, 8'h00, 8'h20, 8'h5A, 32'h0000_0001, 1);
      send(1'b1, 7'h3C, 8'h00, 8'h20, 1'b0);
      wait_done(400);

      // Read with done and nack together: no receive fetch, err 01.
      push_txn(1'b1, 7'h3C, 8'h00, 8'h20, 8'h5A, 32'h0000_0003, 1);
      send(1'b1, 7'h3C, 8'h00, 8'h20, 1'b0);
      wait_done(400);

      // Write with nack but no done.
      push_txn(1'b0, 7'h12, 8'h77, 8'h08, 8'h00, 32'h0000_0002, 1);
      send(1'b0, 7'h12, 8'h77, 8'h08, 1'b0);
      wait_done(400);

      // Timeout: status never reports done.
      push_txn(1'b0, 7'h44, 8'h01, 8'h03, 8'h00, 32'h0, 0);
      send(1'b0, 7'h44, 8'h01, 8'h03, 1'b0);
      wait_done(400);

      // Back-to-back with valid held: second request waits for the response.
      rx_val = 8'hE7;
      push_txn(1'b0, 7'h2A, 8'h3C, 8'h05, 8'h00, 32'h0000_0001, 1);
      push_txn(1'b1, 7'h61, 8'h00, 8'h06, 8'hE7, 32'h0000_0100, 2);
      send(1'b0, 7'h2A, 8'h3C, 8'h05, 1'b1);
      send(1'b1, 7'h61, 8'h00, 8'h06, 1'b0);
      wait_done(800);

      // Slave wait states: bus held stable through long ACCESS phases.
      stall = 4;
      push_txn(1'b0, 7'h6B, 8'h9E, 8'h02, 8'h00, 32'h0000_0001, 1);
      send(1'b0, 7'h6B, 8'h9E, 8'h02, 1'b0);
      wait_done(800);
      stall = 0;

      // Asynchronous reset while polling status.
      push_txn(1'b0, 7'h22, 8'h33, 8'h04, 8'h00, 32'h0, 0);
      send(1'b0, 7'h22, 8'h33, 8'h04, 1'b0);
      ok = 0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge PCLK_i);
         if (PSEL_o && PADDR_o == 8'h05) ok = 1;
      end
      chk("reach_poll", 32'(ok), 32'd1);
      #2 PRESET_N_i = 1'b0;
      #1;
      chk("arst_psel", 32'({PSEL_o, PENABLE_o}), 32'd0);
      chk("arst_ready", 32'(req_ready_o), 32'd1);
      chk("arst_busy", 32'(busy_o), 32'd0);
      chk("arst_rsp", 32'(rsp_valid_o), 32'd0);
      exp_apb.delete(); exp_rd.delete(); exp_err.delete(); exp_lat.delete();
      status_q.delete();
      n_rsp = n_acc;
      repeat (3) begin
         @(posedge PCLK_i); #1;
         chk("arst_no_rsp", 32'(rsp_valid_o), 32'd0);
      end
      @(negedge PCLK_i) PRESET_N_i = 1'b1;
      repeat (2) @(posedge PCLK_i);
      #1;

      // Fresh request after reset runs the full sequence.
      rx_val = 8'hC3;
      push_txn(1'b1, 7'h11, 8'h00, 8'h0F, 8'hC3, 32'h0000_0001, 1);
      send(1'b1, 7'h11, 8'h00, 8'h0F, 1'b0);
      wait_done(400);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
